// File: rtl/four_bit_count_checker.sv
// Receive-side monitor for a free-running 4-bit counter bus: checks every sample is the previous
// sample +1 mod 16, tracks lock, errors and wraps, and latches a sticky fault after ERR_LIMIT errors.
module four_bit_count_checker #(
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned ERR_LIMIT = 3,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a0,
  input  logic             a1,
  input  logic             a2,
  input  logic             a3,
  input  logic             clr,
  output logic             locked,
  output logic             fault,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
  output logic [3:0]       last_value
);

  // The error limit is compared in a widened domain so a narrow CNT_W can never falsely reach it.
  localparam int unsigned ExtW = CNT_W + 8;
  localparam logic [ExtW-1:0]  ErrLimitL = ExtW'(ERR_LIMIT);
  localparam logic [3:0]       LockCntL  = 4'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StAcq,
    StLocked,
    StFault
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [3:0]       r_prev;
  logic [3:0]       r_run;
  logic [3:0]       w_run_next;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] w_err_next;
  logic [CNT_W-1:0] w_err_inc;
  logic [CNT_W-1:0] r_wrap_count;
  logic [CNT_W-1:0] w_wrap_next;
  logic             r_locked;
  logic             r_fault;
  logic             r_err_pulse;
  logic             w_err_pulse_next;
  logic             r_wrap_pulse;
  logic             w_wrap_pulse_next;

  logic [3:0]       w_sample;
  logic [3:0]       w_prev_inc;
  logic [3:0]       w_run_inc;
  logic             w_match;
  logic             w_wrap_seen;
  logic             w_err_limit_hit;

  assign w_sample    = {a3, a2, a1, a0};
  assign w_prev_inc  = r_prev + 4'd1;
  assign w_run_inc   = r_run + 4'd1;
  assign w_match     = (w_sample == w_prev_inc);
  assign w_wrap_seen = (r_prev == 4'hF) && (w_sample == 4'h0);

  // Saturating increment: an all-ones tally holds while the pulse keeps firing.
  assign w_err_inc       = (&r_err_count) ? r_err_count : r_err_count + CntOne;
  assign w_err_limit_hit = ({8'd0, w_err_inc} >= ErrLimitL);

  always_comb begin
    w_state_next      = r_state;
    w_run_next        = r_run;
    w_err_next        = r_err_count;
    w_wrap_next       = r_wrap_count;
    w_err_pulse_next  = 1'b0;
    w_wrap_pulse_next = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_state_next = StAcq;
        w_run_next   = 4'd0;
      end
      StAcq: begin
        if (w_match) begin
          if (w_run_inc == LockCntL) begin
            w_state_next = StLocked;
            w_run_next   = 4'd0;
          end else begin
            w_run_next = w_run_inc;
          end
        end else begin
          w_run_next = 4'd0;
        end
      end
      StLocked: begin
        if (w_match) begin
          if (w_wrap_seen) begin
            w_wrap_pulse_next = 1'b1;
            w_wrap_next       = r_wrap_count + CntOne;
          end
        end else begin
          w_err_pulse_next = 1'b1;
          w_err_next       = w_err_inc;
          w_run_next       = 4'd0;
          w_state_next     = w_err_limit_hit ? StFault : StAcq;
        end
      end
      StFault: begin
        w_state_next = StFault;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_prev       <= 4'd0;
      r_run        <= 4'd0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
      r_locked     <= 1'b0;
      r_fault      <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else if (clr) begin
      r_state      <= StIdle;
      r_prev       <= 4'd0;
      r_run        <= 4'd0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
      r_locked     <= 1'b0;
      r_fault      <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_prev       <= w_sample;
      r_run        <= w_run_next;
      r_err_count  <= w_err_next;
      r_wrap_count <= w_wrap_next;
      r_locked     <= (w_state_next == StLocked);
      r_fault      <= (w_state_next == StFault);
      r_err_pulse  <= w_err_pulse_next;
      r_wrap_pulse <= w_wrap_pulse_next;
    end
  end

  // The previous-sample register always holds the latest sample, so it doubles as last_value.
  assign last_value = r_prev;
  assign locked     = r_locked;
  assign fault      = r_fault;
  assign err_pulse  = r_err_pulse;
  assign wrap_pulse = r_wrap_pulse;
  assign err_count  = r_err_count;
  assign wrap_count = r_wrap_count;

endmodule

// File: doc/four_bit_count_checker.md
Name: four_bit_count_checker

Overview:
- Receive-side monitor for the 4-bit counter output bus (a0..a3, a0 = LSB); runs on the same clock as the counter.
- Samples the bus every rising edge and checks each sample equals the previous sample +1 mod 16.
- Reports lock, per-cycle error and wrap pulses, saturating error and wrap tallies, and a sticky fault.
- Used on board and in simulation to confirm the counter is free-running and correctly ordered.

Parameters:
- LOCK_CNT, 4: consecutive correct increments needed to declare lock (1..15).
- ERR_LIMIT, 3: LOCKED-state errors that force FAULT (1..255).
- CNT_W, 8: width of err_count and wrap_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- a0  input  1  counter bit 0 (LSB).
- a1  input  1  counter bit 1.
- a2  input  1  counter bit 2.
- a3  input  1  counter bit 3 (MSB).
- clr  input  1  synchronous clear, active-high; same effect as reset, but on the clock edge.
- locked  output  1  high while state = LOCKED.
- fault  output  1  sticky; high while state = FAULT.
- err_pulse  output  1  one-cycle pulse per LOCKED-state mismatch.
- wrap_pulse  output  1  one-cycle pulse per 15->0 transition seen while LOCKED.
- err_count  output  CNT_W  LOCKED-state mismatches; saturates at all-ones.
- wrap_count  output  CNT_W  wraps seen while LOCKED; rolls over mod 2^CNT_W.
- last_value  output  4  most recent sampled value {a3,a2,a1,a0}.

Behaviour:
- Sample definitions:
  - s = {a3,a2,a1,a0}, taken at every rising edge.
  - prev = registered copy of the previous s.
  - match = (s == prev + 1, 4-bit, mod 16).
- All outputs are registered. An event sampled at edge N is visible after edge N, for exactly one cycle for pulses.
- Reset (rst low, asynchronous):
  - state = IDLE; prev, last_value, run counter, err_count, wrap_count = 0.
  - locked, fault, err_pulse, wrap_pulse = 0.
  - Reset asserted mid-operation aborts everything immediately, including FAULT.
- clr high at an edge: same values as reset, applied synchronously. clr has priority over all state transitions.
- last_value <= s on every edge, in every state except reset/clr.
- State IDLE: first edge captures prev <= s, run <= 0, goes to ACQ. No checking.
- State ACQ:
  - match: run <= run + 1. When run + 1 == LOCK_CNT, go to LOCKED and clear run.
  - mismatch: run <= 0, stay in ACQ. No error counted, no err_pulse.
- State LOCKED:
  - match: stay in LOCKED.
  - match with prev == 15 and s == 0: also wrap_pulse = 1, wrap_count + 1.
  - mismatch: err_pulse = 1, err_count + 1 (saturating), run <= 0.
  - After a mismatch, if the new err_count value >= ERR_LIMIT, go to FAULT; otherwise go to ACQ.
- State FAULT:
  - fault = 1, locked = 0; no further counting or pulses.
  - last_value still tracks s.
  - Exits only on reset or clr.
- prev <= s on every edge outside reset/clr, regardless of state.
- Because prev is always updated, a single glitched sample causes one mismatch, then resync (the next match is against the glitched value).
- Simultaneous events:
  - err_pulse and wrap_pulse are mutually exclusive, since a wrap requires a match.
  - A saturated err_count stays at all-ones, but err_pulse still fires.
- Lock timing: a stream that starts correct reaches LOCKED after 1 + LOCK_CNT edges from reset release. locked rises after edge 1 + LOCK_CNT.

Test Plan:
1. Reset release, then a correct counter stream 0,1,2,... (LOCK_CNT = 4) -> locked rises after the 5th edge; err_count = 0; wrap_pulse at sample 0 after 15; wrap_count = 2 after 40 edges.
2. While LOCKED, inject the sample 7 where 9 is expected (stream ...8,7,8,9...) -> err_pulse one cycle, err_count = 1, locked drops. The stream 7,8,9,10,11 relocks after 4 matches (locked high after the sample 11).
3. Three separate LOCKED-state glitches (ERR_LIMIT = 3) -> fault = 1 after the 3rd err_pulse; err_count = 3; further glitches produce no pulses; clr high for one edge -> all outputs 0, state IDLE.
4. Stream starting in ACQ with a stuck value 5,5,5,... -> locked stays 0, err_count stays 0, last_value = 5.
5. Assert rst low mid-LOCKED, between edges -> locked, counts and last_value go to 0 immediately, without waiting for a clock edge. Release rst -> relock after 5 edges.
6. CNT_W = 2 with 5 LOCKED-state errors (ERR_LIMIT = 255) -> err_count saturates at 3 while err_pulse still fires 5 times. Separately, 5 wraps -> wrap_count = 1.
